// File: rtl/pulse_stretcher_if.sv
// Purpose : request/status bundle between a pulse source and pulse_stretcher.
// Latency : n/a (wires only).
// Backpressure: none; the pulse source sees busy/pending/overflow as status.
//
// Signals:
//   pulse_in        source -> stretcher  single-cycle request (may repeat every cycle)
//   clear_overflow  source -> stretcher  clears the sticky overflow flag
//   signal_out      stretcher -> far end stretched level, registered
//   busy            stretcher -> source  window in progress or pulses pending
//   pending         stretcher -> source  accepted pulses not yet started
//   overflow        stretcher -> source  sticky, a pulse was dropped
interface pulse_stretcher_if #(
  parameter int CNT_W = 4
) ();
  logic             pulse_in;
  logic             clear_overflow;
  logic             signal_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  // master: the local pulse source
  modport master (
    output pulse_in,
    output clear_overflow,
    input  signal_out,
    input  busy,
    input  pending,
    input  overflow
  );

  // slave: the stretcher itself
  modport slave (
    input  pulse_in,
    input  clear_overflow,
    output signal_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Purpose : turns single-cycle request pulses into HIGH_CYCLES-wide level windows
//           separated by at least LOW_CYCLES low cycles, for a far-domain edge detector.
// Latency : pulse at cycle t (idle, nothing pending) -> signal_out high on t+1..t+HIGH_CYCLES.
// Backpressure: none; pulses during a window are queued in a saturating counter,
//               excess pulses are dropped and flagged by sticky overflow.
//
// Ports:
//   clock   in   single clock, posedge
//   reset   in   synchronous, active-high
//   bus     slave modport of pulse_stretcher_if (pulse_in, clear_overflow in;
//           signal_out, busy, pending, overflow out -- all outputs registered)
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  pulse_stretcher_if.slave   bus
);

  // Phase counter must hold the longer of the two window lengths minus one.
  localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0]  LOW_LOAD  = PH_W'(LOW_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             signal_q, signal_d;

  logic             phase_done;
  logic             window_free;
  logic             start_window;
  logic             accept;
  logic             drop;

  // ---------------------------------------------------------------------------
  // Start / accept / drop decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_done   = (phase_q == '0);
    // A new window may begin from idle, or seamlessly on the final LOW cycle.
    window_free  = (state_q == ST_IDLE) || ((state_q == ST_LOW) && phase_done);
    start_window = window_free && (bus.pulse_in || (pending_q != '0));
    // A full counter can still take a pulse when a start frees a slot the same cycle.
    accept       = bus.pulse_in && !((pending_q == PEND_MAX) && !start_window);
    drop         = bus.pulse_in && (pending_q == PEND_MAX) && !start_window;
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state; phase counts down to zero, zero marks the last cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start_window) begin
          state_d = ST_HIGH;
          phase_d = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (phase_done) begin
          state_d = ST_LOW;
          phase_d = LOW_LOAD;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      ST_LOW: begin
        if (phase_done) begin
          if (start_window) begin
            state_d = ST_HIGH;
            phase_d = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending counter, overflow flag and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    // accept and start together leave the count unchanged (pulse used directly
    // or one queued pulse replaced by the new one); start implies a pulse or a
    // non-zero count, so the decrement never underflows.
    case ({accept, start_window})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase

    // Set has priority over a simultaneous clear.
    overflow_d = drop || (overflow_q && !bus.clear_overflow);

    busy_d   = (state_d != ST_IDLE) || (pending_d != '0);
    signal_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      signal_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      signal_q   <= signal_d;
    end
  end

  assign bus.signal_out = signal_q;
  assign bus.busy       = busy_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three instances (default, CNT_W=2, 8/8 windows)
// driven by one directed sequence; expected window starts and receiver pulses
// are queued when stimulus is driven and popped when the DUT side produces them.
module tb_pulse_stretcher;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_clk = 1'b0;

  always #5 clock = ~clock;
  initial begin
    #2;
    forever #15 rx_clk = ~rx_clk;
  end

  pulse_stretcher_if #(.CNT_W(4)) bus_a ();
  pulse_stretcher_if #(.CNT_W(2)) bus_b ();
  pulse_stretcher_if #(.CNT_W(4)) bus_c ();

  pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));
  pulse_stretcher #(.HIGH_CYCLES(8), .LOW_CYCLES(8), .CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c));

  // Far-end receiver: two-stage synchronizer plus rising-edge detector at 1/3 rate.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   rx_cnt = 0;
  always @(posedge rx_clk) begin
    s1 <= bus_c.signal_out;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3) rx_cnt <= rx_cnt + 1;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  int   mon_sel  = 0;
  logic prev_so  = 1'b0;
  int   rise_q[$];
  int   sb_q[$];
  int   rx_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic mon_so();
    case (mon_sel)
      0:       return bus_a.signal_out;
      1:       return bus_b.signal_out;
      default: return bus_c.signal_out;
    endcase
  endfunction

  // Advance one clock; sample #1 after the edge; pop scoreboards on DUT events.
  task automatic step();
    logic so;
    int   exp_v;
    @(posedge clock);
    #1;
    cyc++;
    so = mon_so();
    if (mon_en && so && !prev_so) begin
      exp_v = (rise_q.size() != 0) ? rise_q.pop_front() : -1;
      chk($sformatf("rise_cycle@%0d", cyc), cyc, exp_v);
    end
    prev_so = so;
    while (rx_seen != rx_cnt) begin
      exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : -1;
      chk($sformatf("rx_pulse#%0d", rx_seen), rx_seen, exp_v);
      rx_seen++;
    end
  endtask

  task automatic idle_inputs();
    bus_a.pulse_in = 1'b0; bus_a.clear_overflow = 1'b0;
    bus_b.pulse_in = 1'b0; bus_b.clear_overflow = 1'b0;
    bus_c.pulse_in = 1'b0; bus_c.clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    prev_so = mon_so();
  endtask

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic int pend3(input int d);
    if (d == 12) return 1;
    if (d == 13) return 2;
    if (in_rng(d, 14, 18)) return 3;
    if (in_rng(d, 19, 26)) return 2;
    if (in_rng(d, 27, 34)) return 1;
    return 0;
  endfunction

  initial begin
    idle_inputs();

    // ---- Test 1: single pulse, default parameters ----
    mon_en = 1'b1; mon_sel = 0;
    do_reset();
    chk("rst_signal_out", bus_a.signal_out, 0);
    chk("rst_busy",       bus_a.busy, 0);
    chk("rst_pending",    bus_a.pending, 0);
    chk("rst_overflow",   bus_a.overflow, 0);
    while (cyc <= 22) begin
      chk($sformatf("t1_so@%0d", cyc),   bus_a.signal_out, in_rng(cyc, 11, 14));
      chk($sformatf("t1_busy@%0d", cyc), bus_a.busy,       in_rng(cyc, 11, 18));
      chk($sformatf("t1_pend@%0d", cyc), bus_a.pending,    0);
      bus_a.pulse_in = (cyc == 10);
      if (cyc == 10) rise_q.push_back(cyc + 1);
      step();
    end
    chk("t1_rise_q_empty", rise_q.size(), 0);

    // ---- Test 2: three back-to-back pulses replayed in order ----
    do_reset();
    while (cyc <= 38) begin
      chk($sformatf("t2_so@%0d", cyc), bus_a.signal_out,
          in_rng(cyc, 11, 14) || in_rng(cyc, 19, 22) || in_rng(cyc, 27, 30));
      chk($sformatf("t2_busy@%0d", cyc), bus_a.busy, in_rng(cyc, 11, 34));
      chk($sformatf("t2_pend@%0d", cyc), bus_a.pending,
          (cyc == 12) ? 1 : in_rng(cyc, 13, 18) ? 2 : in_rng(cyc, 19, 26) ? 1 : 0);
      bus_a.pulse_in = in_rng(cyc, 10, 12);
      if (in_rng(cyc, 10, 12)) rise_q.push_back(11 + 8 * (cyc - 10));
      step();
    end
    chk("t2_rise_q_empty", rise_q.size(), 0);

    // ---- Test 3: CNT_W=2 saturation, overflow, clear, set-beats-clear ----
    mon_sel = 1;
    do_reset();
    while (cyc <= 90) begin
      int d;
      d = (cyc >= 50) ? cyc - 40 : cyc;
      chk($sformatf("t3_so@%0d", cyc), bus_b.signal_out,
          in_rng(d, 11, 14) || in_rng(d, 19, 22) || in_rng(d, 27, 30) || in_rng(d, 35, 38));
      chk($sformatf("t3_busy@%0d", cyc), bus_b.busy, in_rng(d, 11, 42));
      chk($sformatf("t3_pend@%0d", cyc), bus_b.pending, pend3(d));
      chk($sformatf("t3_ovf@%0d", cyc), bus_b.overflow,
          in_rng(cyc, 15, 40) || in_rng(cyc, 55, 85));
      bus_b.pulse_in       = in_rng(cyc, 10, 14) || in_rng(cyc, 50, 54);
      bus_b.clear_overflow = (cyc == 40) || (cyc == 54) || (cyc == 85);
      if (in_rng(cyc, 10, 13)) rise_q.push_back(11 + 8 * (cyc - 10));
      if (in_rng(cyc, 50, 53)) rise_q.push_back(51 + 8 * (cyc - 50));
      step();
    end
    chk("t3_rise_q_empty", rise_q.size(), 0);

    // ---- Test 4: second pulse on the last LOW cycle, no gap ----
    mon_sel = 0;
    do_reset();
    while (cyc <= 30) begin
      chk($sformatf("t4_so@%0d", cyc), bus_a.signal_out,
          in_rng(cyc, 11, 14) || in_rng(cyc, 19, 22));
      chk($sformatf("t4_busy@%0d", cyc), bus_a.busy, in_rng(cyc, 11, 26));
      chk($sformatf("t4_pend@%0d", cyc), bus_a.pending, 0);
      bus_a.pulse_in = (cyc == 10) || (cyc == 18);
      if (cyc == 10 || cyc == 18) rise_q.push_back(cyc + 1);
      step();
    end
    chk("t4_rise_q_empty", rise_q.size(), 0);

    // ---- Test 5: reset mid-window discards everything ----
    do_reset();
    while (cyc <= 30) begin
      chk($sformatf("t5_so@%0d", cyc),   bus_a.signal_out, in_rng(cyc, 11, 12));
      chk($sformatf("t5_busy@%0d", cyc), bus_a.busy,       in_rng(cyc, 11, 12));
      chk($sformatf("t5_pend@%0d", cyc), bus_a.pending,    (cyc == 12) ? 1 : 0);
      chk($sformatf("t5_ovf@%0d", cyc),  bus_a.overflow,   0);
      bus_a.pulse_in = in_rng(cyc, 10, 12);
      reset = (cyc == 12);
      if (cyc == 10) rise_q.push_back(cyc + 1);
      step();
    end
    chk("t5_rise_q_empty", rise_q.size(), 0);

    // ---- Test 6: end-to-end through a slower receiver ----
    mon_en = 1'b0; mon_sel = 2;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      sb_q.push_back(i);
      bus_c.pulse_in = 1'b1;
      step();
      bus_c.pulse_in = 1'b0;
      repeat ($urandom_range(8, 32)) step();
    end
    begin
      int budget;
      budget = 3000;
      while (bus_c.busy && budget > 0) begin
        step();
        budget--;
      end
      chk("t6_drain_busy", bus_c.busy, 0);
    end
    repeat (40) step();
    chk("t6_rx_count",    rx_seen, 50);
    chk("t6_sb_empty",    sb_q.size(), 0);
    chk("t6_no_overflow", bus_c.overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Transmit-side companion to the receiver's two-stage synchronizer and rising-edge detector. Converts single-cycle request pulses in the local `clock` domain into a level `signal_out` for another clock domain. Each pulse becomes one high window of programmable width, followed by a mandatory low gap, so the far-end synchronizer sees exactly one rising edge per accepted pulse. Pulses that arrive while a window is in progress are counted and replayed in order; overflow is flagged, never silently merged.

Parameters:
HIGH_CYCLES, 4, clock cycles `signal_out` stays high per pulse; >=1; size for >=3 receiver clock periods.
LOW_CYCLES, 4, minimum clock cycles `signal_out` stays low after each high window; >=1; same sizing rule.
CNT_W, 4, width of pending-pulse counter; max pending = 2^CNT_W-1.

Ports:
clock  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
pulse_in  input  1  one request per cycle high; may be high on consecutive cycles.
clear_overflow  input  1  clears sticky overflow.
signal_out  output  1  stretched level to the far domain; registered, glitch-free.
busy  output  1  high while a window is in progress or pulses are pending.
pending  output  CNT_W  accepted pulses whose high window has not yet started.
overflow  output  1  sticky; a pulse was dropped.

Behaviour:
- All outputs registered. Reset values: `signal_out`=0, `busy`=0, `pending`=0, `overflow`=0, state=IDLE, phase counter=0.
- FSM states: IDLE, HIGH, LOW. `signal_out`=1 exactly when state==HIGH.
- start = (state==IDLE, or last cycle of LOW) and (pulse_in or pending!=0).
- On start: next state HIGH, phase counter loaded.
- HIGH lasts exactly HIGH_CYCLES cycles, then goes to LOW.
- At the end of LOW (LOW_CYCLES cycles): go to HIGH if start, else IDLE. There is no extra idle cycle between back-to-back windows.
- Latency: `pulse_in` at cycle t with FSM idle and pending==0 gives `signal_out`=1 on cycles t+1 .. t+HIGH_CYCLES.
- Counter update: pending_next = pending + acc - start, where acc = pulse_in and not (pending==MAX and not start).
  - Case pulse_in and start in the same cycle with pending==0: counter is unchanged (the pulse is consumed directly).
  - Case pending==MAX and start with pulse_in: counter stays MAX.
- Overflow: pulse_in and pending==MAX and not start → pulse dropped, `overflow`=1 next cycle.
  - `overflow` holds until `clear_overflow`.
  - If set and clear occur in the same cycle, set wins.
- `busy` (registered) = (next state != IDLE) or (pending_next != 0).
- Reset mid-operation, in any state:
  - Next edge forces all reset values; `signal_out` drops immediately even mid-window.
  - pulse_in during reset is ignored.
  - Pending pulses are discarded.
- No arithmetic wrap: the pending counter saturates at MAX and never underflows, since start implies pulse_in or pending>0.

Test Plan:
1. Defaults; single pulse_in at cycle 10 → `signal_out`=1 on cycles 11-14, 0 on 15-18. `busy`=1 on 11-18, 0 at 19. `pending` stays 0.
2. pulse_in at cycles 10, 11, 12 → `pending`=1 at 12, 2 at 13. High windows at 11-14, 19-22, 27-30, separated by exactly 4 low cycles. `pending`=1 at 19, 0 at 27. `busy`=0 at 35.
3. CNT_W=2; pulse_in on cycles 10-14 → `pending` reaches 3 at 14. Pulse at 14 is dropped; `overflow`=1 at 15. Exactly 4 high windows follow. `clear_overflow` at 40 → `overflow`=0 at 41. Simultaneous set+clear leaves `overflow`=1.
4. pulse_in at 10, second pulse_in exactly at cycle 18 (last LOW cycle) → second high window at 19-22 with no gap. `pending` stays 0 throughout.
5. pulse_in at 10 and 11, reset at cycle 12 → at 13: `signal_out`=0, `pending`=0, `busy`=0. No further windows. pulse_in during reset produces nothing.
6. End-to-end: receiver synchronizer/edge detector clocked at 1/3 this frequency, HIGH_CYCLES=LOW_CYCLES=8, 50 random pulse_in without overflow → receiver emits exactly 50 single-cycle pulses.
